// File: rtl/chromosome_evaluation_sequencer.sv
// -----------------------------------------------------------------------------
// chromosome_evaluation_sequencer
//
// Plays a stimulus table into a candidate circuit (phenotype) as a sequence of
// vectors. Each vector is accompanied by a slow stimulus clock made of one high
// phase and one low phase. At the end of each low phase, the circuit response
// is compared bit by bit against an expected table. A saturating mismatch count
// is accumulated for every output bit. The block then reports the per-bit sums,
// their total and a "perfect" flag.
//
// Ports
//   iClock           system clock
//   iReset_n         synchronous active-low reset
//   iStart           begin evaluation (IDLE only)
//   iAbort           cancel evaluation (RUN only)
//   iDoneAck         result consumed (DONE only)
//   iInputSequence   stimulus table, vector k at [k*IN_WIDTH +: IN_WIDTH]
//   iExpectedOutput  expected response table, same packing with OUT_WIDTH
//   iChromOutput     response of the phenotype under test
//   oStimulus        {current vector, stimulus clock level}
//   oReady / oDone   high in IDLE / DONE
//   oErrorSums       per-output-bit mismatch counts, bit b at [b*SUM_WIDTH +: SUM_WIDTH]
//   oTotalErrors     sum of all per-bit counts
//   oPerfect         DONE with zero total errors
//   oState           IDLE=0, RUN=1, DONE=2
//   oVectorIndex     current vector within the pass
//   oPassIndex       current pass
// -----------------------------------------------------------------------------
module chromosome_evaluation_sequencer #(
  parameter int IN_WIDTH    = 8,
  parameter int OUT_WIDTH   = 8,
  parameter int NUM_VECTORS = 16,
  parameter int HALF_PERIOD = 100,
  parameter int NUM_PASSES  = 1,
  parameter int SUM_WIDTH   = 32
) (
  input  logic                                     iClock,
  input  logic                                     iReset_n,
  input  logic                                     iStart,
  input  logic                                     iAbort,
  input  logic                                     iDoneAck,
  input  logic [NUM_VECTORS*IN_WIDTH-1:0]          iInputSequence,
  input  logic [NUM_VECTORS*OUT_WIDTH-1:0]         iExpectedOutput,
  input  logic [OUT_WIDTH-1:0]                     iChromOutput,
  output logic [IN_WIDTH:0]                        oStimulus,
  output logic                                     oReady,
  output logic                                     oDone,
  output logic [OUT_WIDTH*SUM_WIDTH-1:0]           oErrorSums,
  output logic [SUM_WIDTH+$clog2(OUT_WIDTH)-1:0]   oTotalErrors,
  output logic                                     oPerfect,
  output logic [1:0]                               oState,
  output logic [$clog2(NUM_VECTORS)-1:0]           oVectorIndex,
  output logic [$clog2(NUM_PASSES):0]              oPassIndex
);

  localparam int VW  = $clog2(NUM_VECTORS);
  localparam int PW  = $clog2(NUM_PASSES) + 1;
  localparam int PHW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int TW  = SUM_WIDTH + $clog2(OUT_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [PHW-1:0]         phase_q, phase_d;
  logic                   level_q, level_d;
  logic [VW-1:0]          vec_q, vec_d;
  logic [PW-1:0]          pass_q, pass_d;
  logic [SUM_WIDTH-1:0]   sums_q [OUT_WIDTH];
  logic [SUM_WIDTH-1:0]   sums_d [OUT_WIDTH];

  logic                   phase_end;
  logic                   sample;
  logic                   last_vec;
  logic                   last_pass;
  logic [OUT_WIDTH-1:0]   exp_vec;
  logic [OUT_WIDTH-1:0]   mismatch;
  logic [TW-1:0]          total;

  // Counts stick at all-ones instead of wrapping back to a small value.
  function automatic logic [SUM_WIDTH-1:0] sat_inc(input logic [SUM_WIDTH-1:0] v);
    return (&v) ? v : v + SUM_WIDTH'(1);
  endfunction

  assign phase_end = (phase_q == PHW'(HALF_PERIOD - 1));
  assign sample    = (state_q == S_RUN) && !level_q && phase_end;
  assign last_vec  = (vec_q == VW'(NUM_VECTORS - 1));
  assign last_pass = (pass_q == PW'(NUM_PASSES - 1));
  assign exp_vec   = iExpectedOutput[vec_q*OUT_WIDTH +: OUT_WIDTH];
  assign mismatch  = iChromOutput ^ exp_vec;

  // Next-state logic. Outside RUN the sequencing counters are parked at
  // phase 0 / vector 0 / pass 0 / level 1, so they are cleared on every exit
  // from RUN and the IDLE->RUN edge finds them already at their start values.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    level_d = level_q;
    vec_d   = vec_q;
    pass_d  = pass_q;
    sums_d  = sums_q;

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d = S_RUN;
          for (int b = 0; b < OUT_WIDTH; b++) sums_d[b] = '0;
        end
      end

      S_RUN: begin
        if (sample) begin
          for (int b = 0; b < OUT_WIDTH; b++) begin
            if (mismatch[b]) sums_d[b] = sat_inc(sums_q[b]);
          end
        end

        if (phase_end) begin
          phase_d = '0;
          level_d = ~level_q;
          // The vector advances as the level returns high.
          if (!level_q) begin
            if (last_vec) begin
              vec_d  = '0;
              pass_d = pass_q + PW'(1);
            end else begin
              vec_d = vec_q + VW'(1);
            end
          end
        end else begin
          phase_d = phase_q + PHW'(1);
        end

        // Abort wins over completion; the final sample above is still kept.
        if (iAbort || (sample && last_vec && last_pass)) begin
          state_d = iAbort ? S_IDLE : S_DONE;
          phase_d = '0;
          level_d = 1'b1;
          vec_d   = '0;
          pass_d  = '0;
        end
      end

      S_DONE: begin
        if (iDoneAck) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        phase_d = '0;
        level_d = 1'b1;
        vec_d   = '0;
        pass_d  = '0;
      end
    endcase
  end

  always_ff @(posedge iClock) begin
    if (!iReset_n) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      level_q <= 1'b1;
      vec_q   <= '0;
      pass_q  <= '0;
      for (int b = 0; b < OUT_WIDTH; b++) sums_q[b] <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      level_q <= level_d;
      vec_q   <= vec_d;
      pass_q  <= pass_d;
      sums_q  <= sums_d;
    end
  end

  always_comb begin
    oErrorSums = '0;
    total      = '0;
    for (int b = 0; b < OUT_WIDTH; b++) begin
      oErrorSums[b*SUM_WIDTH +: SUM_WIDTH] = sums_q[b];
      total = total + TW'(sums_q[b]);
    end
  end

  assign oTotalErrors = total;
  assign oStimulus    = {iInputSequence[vec_q*IN_WIDTH +: IN_WIDTH], level_q};
  assign oReady       = (state_q == S_IDLE);
  assign oDone        = (state_q == S_DONE);
  assign oPerfect     = (state_q == S_DONE) && (total == '0);
  assign oState       = state_q;
  assign oVectorIndex = vec_q;
  assign oPassIndex   = pass_q;

endmodule

// File: tb/tb_chromosome_evaluation_sequencer.sv
module tb_chromosome_evaluation_sequencer;

  localparam int IW  = 8;
  localparam int OW  = 8;
  localparam int NV  = 4;
  localparam int HP  = 3;
  localparam int SWA = 32;
  localparam int SWB = 2;
  localparam int NPA = 1;
  localparam int NPB = 2;

  logic iClock = 1'b0;
  always #5 iClock = ~iClock;

  logic              rst_n, start, abort_i, ack;
  logic [NV*IW-1:0]  in_seq;
  logic [NV*OW-1:0]  exp_out;
  logic [OW-1:0]     chrom;

  logic [IW:0]       stim_a, stim_b;
  logic              ready_a, done_a, perf_a, ready_b, done_b, perf_b;
  logic [OW*SWA-1:0] sums_a;
  logic [OW*SWB-1:0] sums_b;
  logic [SWA+2:0]    tot_a;
  logic [SWB+2:0]    tot_b;
  logic [1:0]        st_a, st_b, vi_a, vi_b;
  logic [0:0]        pi_a;
  logic [1:0]        pi_b;

  chromosome_evaluation_sequencer #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM_VECTORS(NV), .HALF_PERIOD(HP),
    .NUM_PASSES(NPA), .SUM_WIDTH(SWA)
  ) dut_a (
    .iClock(iClock), .iReset_n(rst_n), .iStart(start), .iAbort(abort_i),
    .iDoneAck(ack), .iInputSequence(in_seq), .iExpectedOutput(exp_out),
    .iChromOutput(chrom), .oStimulus(stim_a), .oReady(ready_a), .oDone(done_a),
    .oErrorSums(sums_a), .oTotalErrors(tot_a), .oPerfect(perf_a), .oState(st_a),
    .oVectorIndex(vi_a), .oPassIndex(pi_a)
  );

  chromosome_evaluation_sequencer #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM_VECTORS(NV), .HALF_PERIOD(HP),
    .NUM_PASSES(NPB), .SUM_WIDTH(SWB)
  ) dut_b (
    .iClock(iClock), .iReset_n(rst_n), .iStart(start), .iAbort(abort_i),
    .iDoneAck(ack), .iInputSequence(in_seq), .iExpectedOutput(exp_out),
    .iChromOutput(chrom), .oStimulus(stim_b), .oReady(ready_b), .oDone(done_b),
    .oErrorSums(sums_b), .oTotalErrors(tot_b), .oPerfect(perf_b), .oState(st_b),
    .oVectorIndex(vi_b), .oPassIndex(pi_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: state 0/1/2, run-cycle count t since RUN entry, sums.
  int               mst [2];
  int               mt  [2];
  longint unsigned  msum[2][OW];

  function automatic int np(input int d);
    return (d == 0) ? NPA : NPB;
  endfunction

  function automatic int sw(input int d);
    return (d == 0) ? SWA : SWB;
  endfunction

  function automatic longint unsigned smax(input int d);
    return (d == 0) ? 64'hFFFF_FFFF : 64'd3;
  endfunction

  function automatic int cur_vec(input int d);
    return (mst[d] == 1) ? (mt[d] / (2*HP)) % NV : 0;
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        mst[d] = 0; mt[d] = 0;
        for (int b = 0; b < OW; b++) msum[d][b] = 0;
      end else begin
        case (mst[d])
          0: if (start) begin
               mst[d] = 1; mt[d] = 0;
               for (int b = 0; b < OW; b++) msum[d][b] = 0;
             end
          1: begin
               if (mt[d] % (2*HP) == 2*HP-1) begin
                 int v;
                 v = (mt[d] / (2*HP)) % NV;
                 for (int b = 0; b < OW; b++)
                   if (chrom[b] != exp_out[v*OW + b] && msum[d][b] < smax(d)) msum[d][b]++;
               end
               if (abort_i) begin mst[d] = 0; mt[d] = 0; end
               else if (mt[d] == np(d)*NV*2*HP - 1) begin mst[d] = 2; mt[d] = 0; end
               else mt[d]++;
             end
          default: if (ack) mst[d] = 0;
        endcase
      end
    end
  endtask

  task automatic check_dut(input int d, input string p,
                           input logic [255:0] st, input logic [255:0] stim,
                           input logic [255:0] vi, input logic [255:0] pi,
                           input logic [255:0] sums, input logic [255:0] tot,
                           input logic rdy, input logic dn, input logic pf);
    int v, ps;
    logic lvl;
    logic [IW:0] es_stim;
    logic [255:0] es;
    longint unsigned t;
    if (mst[d] == 1) begin
      v = (mt[d] / (2*HP)) % NV;
      ps = mt[d] / (2*NV*HP);
      lvl = ((mt[d] / HP) % 2) == 0;
    end else begin
      v = 0; ps = 0; lvl = 1'b1;
    end
    es_stim = {in_seq[v*IW +: IW], lvl};
    es = '0; t = 0;
    for (int b = 0; b < OW; b++) begin
      es = es | (256'(msum[d][b]) << (b*sw(d)));
      t += msum[d][b];
    end
    chk({p, ".state"}, st, 256'(mst[d]));
    chk({p, ".stim"}, stim, 256'(es_stim));
    chk({p, ".vidx"}, vi, 256'(v));
    chk({p, ".pidx"}, pi, 256'(ps));
    chk({p, ".sums"}, sums, es);
    chk({p, ".total"}, tot, 256'(t));
    chk({p, ".ready"}, 256'(rdy), 256'(mst[d] == 0));
    chk({p, ".done"}, 256'(dn), 256'(mst[d] == 2));
    chk({p, ".perfect"}, 256'(pf), 256'(mst[d] == 2 && t == 0));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge iClock);
    #1;
    check_dut(0, "A", 256'(st_a), 256'(stim_a), 256'(vi_a), 256'(pi_a), 256'(sums_a), 256'(tot_a),
              ready_a, done_a, perf_a);
    check_dut(1, "B", 256'(st_b), 256'(stim_b), 256'(vi_b), 256'(pi_b), 256'(sums_b), 256'(tot_b),
              ready_b, done_b, perf_b);
  endtask

  int  cnt_a, cnt_b;
  logic seen_done;

  initial begin
    for (int d = 0; d < 2; d++) begin
      mst[d] = 0; mt[d] = 0;
      for (int b = 0; b < OW; b++) msum[d][b] = 0;
    end
    rst_n = 1'b0; start = 1'b0; abort_i = 1'b0; ack = 1'b0;
    in_seq = $urandom; exp_out = $urandom; chrom = '0;

    // Reset state
    repeat (2) cycle();
    rst_n = 1'b1;
    chk("rst.ready", 256'(ready_a), 256'd1);
    chk("rst.stim", 256'(stim_a), 256'({in_seq[IW-1:0], 1'b1}));
    chk("rst.total", 256'(tot_a), 256'd0);

    // Perfect evaluation: the response follows the expected table live
    start = 1'b1; chrom = exp_out[OW-1:0]; cycle(); start = 1'b0;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 200 && (st_a == 2'd1 || st_b == 2'd1); i++) begin
      if (st_a == 2'd1) cnt_a++;
      if (st_b == 2'd1) cnt_b++;
      chrom = exp_out[cur_vec(1)*OW +: OW];
      cycle();
    end
    chk("perfect.runlenA", 256'(cnt_a), 256'd24);
    chk("perfect.runlenB", 256'(cnt_b), 256'd48);
    chk("perfect.flagA", 256'(perf_a), 256'd1);
    chk("perfect.flagB", 256'(perf_b), 256'd1);
    ack = 1'b1; cycle(); ack = 1'b0;
    chk("perfect.ackA", 256'(st_a), 256'd0);

    // All bits mismatched, with ignored iStart pulses in RUN and DONE
    exp_out = '1; chrom = '0;
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < 200 && (st_a == 2'd1 || st_b == 2'd1); i++) begin
      start = (i == 5);
      cycle();
    end
    start = 1'b0;
    chk("mis.sumsA", 256'(sums_a), {8{32'd4}});
    chk("mis.totalA", 256'(tot_a), 256'd32);
    chk("mis.sumsB_sat", 256'(sums_b), 256'({8{2'd3}}));
    chk("mis.totalB", 256'(tot_b), 256'd24);
    start = 1'b1; cycle(); start = 1'b0;
    chk("mis.startInDone", 256'(st_a), 256'd2);
    ack = 1'b1; cycle(); ack = 1'b0;
    chk("mis.ackIdle", 256'(st_a), 256'd0);
    repeat (3) cycle();
    chk("mis.sumsHeld", 256'(sums_a), {8{32'd4}});
    start = 1'b1; cycle(); start = 1'b0;
    chk("mis.sumsClear", 256'(sums_a), 256'd0);

    // Abort at run cycle 10
    seen_done = 1'b0;
    for (int i = 0; i < 100 && mt[0] != 10; i++) begin
      cycle();
      if (done_a) seen_done = 1'b1;
    end
    abort_i = 1'b1; cycle(); abort_i = 1'b0;
    if (done_a) seen_done = 1'b1;
    chk("abort.state", 256'(st_a), 256'd0);
    chk("abort.sumsA", 256'(sums_a), {8{32'd1}});
    chk("abort.sumsB", 256'(sums_b), 256'({8{2'd1}}));
    repeat (4) begin cycle(); if (done_a) seen_done = 1'b1; end
    chk("abort.noDone", 256'(seen_done), 256'd0);

    // Reset at run cycle 7
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < 100 && mt[0] != 7; i++) cycle();
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    chk("midrst.state", 256'(st_a), 256'd0);
    chk("midrst.ready", 256'(ready_a), 256'd1);
    chk("midrst.done", 256'(done_a), 256'd0);
    chk("midrst.stim", 256'(stim_a), 256'({in_seq[IW-1:0], 1'b1}));
    chk("midrst.sums", 256'(sums_a), 256'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst_n   = ($urandom % 400) != 0;
      start   = ($urandom % 8) == 0;
      abort_i = ($urandom % 80) == 0;
      ack     = ($urandom % 4) == 0;
      if ($urandom % 60 == 0) in_seq = $urandom;
      if ($urandom % 60 == 0) exp_out = $urandom;
      if ($urandom % 2 == 0) chrom = exp_out[cur_vec(0)*OW +: OW] ^ OW'(($urandom % 4 == 0) ? $urandom : 0);
      else chrom = OW'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
